// File: rtl/programmable_counter.sv
// ---------------------------------------------------------------------------
// programmable_counter
//
// 8-bit programmable up/down counter with a loadable count and a loadable
// terminal (limit) value. At a boundary the counter either wraps or
// saturates. The block uses the standard ui_in/uo_out/uio harness interface.
//
// Ports
//   clk      in   1  system clock, rising-edge active
//   rst_n    in   1  asynchronous reset, ACTIVE HIGH despite the _n suffix
//                    (1 = reset): count -> 8'h00, limit -> 8'hFF
//   ena      in   1  design enable; when 0 all registers hold
//   ui_in    in   8  [0] cnt_en  [1] load  [2] dir (1 = up)
//                    [3] load_limit  [4] sat_mode (1 = saturate)
//                    [7:5] ignored
//   uo_out   out  8  current count, straight from the register
//   uio_in   in   8  parallel data for count and limit loads
//   uio_out  out  8  constant 8'h00
//   uio_oe   out  8  constant 8'h00 (all uio pins are inputs)
// ---------------------------------------------------------------------------
module programmable_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Control bit positions within ui_in.
  localparam int CNT_EN_BIT     = 0;
  localparam int LOAD_BIT       = 1;
  localparam int DIR_BIT        = 2;
  localparam int LOAD_LIMIT_BIT = 3;
  localparam int SAT_MODE_BIT   = 4;

  localparam logic [7:0] COUNT_RESET = 8'h00;
  localparam logic [7:0] LIMIT_RESET = 8'hFF;

  logic       cnt_en;
  logic       load;
  logic       dir_up;
  logic       load_limit;
  logic       sat_mode;

  logic [7:0] count;
  logic [7:0] limit;
  logic [7:0] count_next;
  logic [7:0] limit_next;

  assign cnt_en     = ui_in[CNT_EN_BIT];
  assign load       = ui_in[LOAD_BIT];
  assign dir_up     = ui_in[DIR_BIT];
  assign load_limit = ui_in[LOAD_LIMIT_BIT];
  assign sat_mode   = ui_in[SAT_MODE_BIT];

  // ui_in[7:5] carry no function; fold them into one sink so the intent
  // of leaving them unconnected is explicit.
  logic unused_ui_bits;
  assign unused_ui_bits = ^ui_in[7:5];

  // Count next-state. Boundary tests use the registered limit, so a limit
  // loaded in the same cycle only affects counting from the next cycle on.
  always_comb begin
    // NOTE: default assignment first so every path assigns count_next;
    // without it a missing else would infer a latch.
    count_next = count;
    if (load) begin
      count_next = uio_in;
    end else if (cnt_en) begin
      if (dir_up) begin
        // ">=" rather than "==" so a count sitting above the limit (after a
        // load or a limit decrease) is treated as the boundary too.
        if (count >= limit) begin
          count_next = sat_mode ? count : 8'h00;
        end else begin
          count_next = count + 8'd1;
        end
      end else begin
        if (count == 8'h00) begin
          count_next = sat_mode ? count : limit;
        end else begin
          count_next = count - 8'd1;
        end
      end
    end
  end

  // Limit load is independent of whatever the count does this cycle.
  assign limit_next = load_limit ? uio_in : limit;

  // Reset is active high on a port named rst_n, hence posedge rst_n.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      // NOTE: non-blocking assignments for registered state so every flop
      // samples pre-edge values regardless of statement order.
      count <= COUNT_RESET;
      limit <= LIMIT_RESET;
    end else if (ena) begin
      count <= count_next;
      limit <= limit_next;
    end
  end

  assign uo_out  = count;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_programmable_counter.sv
// ---------------------------------------------------------------------------
// tb_programmable_counter
//
// Directed self-checking bench for programmable_counter. Inputs are changed
// 1 ns after a rising edge and outputs are sampled at the same point, well
// away from the active edge. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_programmable_counter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  // ui_in encodings: {sat, load_limit, dir, load, cnt_en}
  localparam logic [7:0] IDLE      = 8'b0000_0000;
  localparam logic [7:0] UP        = 8'b0000_0101;
  localparam logic [7:0] DOWN      = 8'b0000_0001;
  localparam logic [7:0] LOAD      = 8'b0000_0010;
  localparam logic [7:0] LOAD_EN   = 8'b0000_0011;
  localparam logic [7:0] LIM       = 8'b0000_1000;
  localparam logic [7:0] LIM_UP    = 8'b0000_1101;
  localparam logic [7:0] SAT_UP    = 8'b0001_0101;
  localparam logic [7:0] SAT_DOWN  = 8'b0001_0001;
  localparam logic [7:0] SAT_LOAD  = 8'b0001_0010;

  programmable_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_uio(input string tag);
    check({tag, "_uio_out"}, uio_out, 8'h00);
    check({tag, "_uio_oe"},  uio_oe,  8'h00);
  endtask

  // Watchdog: the sequence below is a few thousand ns long.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset pulse between edges (first rising edge is at 5 ns).
    #2 rst_n = 1'b1;
    #1 check("reset_async", uo_out, 8'h00);
    check_uio("reset");
    rst_n = 1'b0;
    tick(1);
    check("after_release_idle", uo_out, 8'h00);

    // Count up with default limit 0xFF in wrap mode.
    ui_in = UP;
    tick(5);
    check("up_5", uo_out, 8'h05);
    tick(250);
    check("up_255", uo_out, 8'hFF);
    tick(1);
    check("wrap_ff_to_0", uo_out, 8'h00);

    // Load has priority over cnt_en; then count down.
    uio_in = 8'h42;
    ui_in  = LOAD_EN;
    tick(1);
    check("load_priority", uo_out, 8'h42);
    ui_in = DOWN;
    tick(3);
    check("down_3", uo_out, 8'h3F);

    // Programmable limit = 9.
    uio_in = 8'h09;
    ui_in  = LIM;
    tick(1);
    check("limit_load_holds_count", uo_out, 8'h3F);
    uio_in = 8'h00;
    ui_in  = LOAD;
    tick(1);
    check("load_zero", uo_out, 8'h00);
    ui_in = UP;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      check($sformatf("lim9_up_%0d", k), uo_out, 8'(k % 10));
    end
    ui_in = DOWN;
    tick(1);
    check("down_wrap_to_limit", uo_out, 8'h09);

    // Same-cycle limit load: old limit (9) governs this edge -> wrap to 0.
    uio_in = 8'h14;
    ui_in  = LIM_UP;
    tick(1);
    check("same_cycle_limit_old", uo_out, 8'h00);
    ui_in = UP;
    tick(10);
    check("new_limit_20_active", uo_out, 8'h0A);
    // Restore limit 9 and count 0.
    uio_in = 8'h09;
    ui_in  = LIM;
    tick(1);
    uio_in = 8'h00;
    ui_in  = LOAD;
    tick(1);
    check("reload_zero", uo_out, 8'h00);

    // Saturate mode with limit 9.
    ui_in = SAT_UP;
    tick(9);
    check("sat_up_reach_9", uo_out, 8'h09);
    tick(1);
    check("sat_up_hold_9", uo_out, 8'h09);
    ui_in = SAT_DOWN;
    tick(9);
    check("sat_down_reach_0", uo_out, 8'h00);
    tick(1);
    check("sat_down_hold_0", uo_out, 8'h00);

    // Enable gating.
    ui_in = UP;
    tick(3);
    check("pre_gate", uo_out, 8'h03);
    ena = 1'b0;
    tick(5);
    check("ena0_count_hold", uo_out, 8'h03);
    uio_in = 8'hAA;
    ui_in  = LOAD;
    tick(1);
    check("ena0_load_ignored", uo_out, 8'h03);
    ena   = 1'b1;
    ui_in = UP;
    tick(2);
    check("ena1_resume", uo_out, 8'h05);

    // Mid-count reset between edges; limit must return to 0xFF.
    rst_n = 1'b1;
    #2 check("reset_mid_async", uo_out, 8'h00);
    rst_n = 1'b0;
    tick(10);
    check("post_reset_past_9", uo_out, 8'h0A);
    tick(245);
    check("post_reset_255", uo_out, 8'hFF);
    tick(1);
    check("post_reset_wrap", uo_out, 8'h00);

    // Count above limit: limit 0x10, count 0x50.
    uio_in = 8'h10;
    ui_in  = LIM;
    tick(1);
    uio_in = 8'h50;
    ui_in  = LOAD;
    tick(1);
    check("load_above_limit", uo_out, 8'h50);
    ui_in = UP;
    tick(1);
    check("above_limit_wrap", uo_out, 8'h00);
    uio_in = 8'h50;
    ui_in  = SAT_LOAD;
    tick(1);
    ui_in = SAT_UP;
    tick(1);
    check("above_limit_sat_hold", uo_out, 8'h50);
    ui_in = SAT_DOWN;
    tick(1);
    check("above_limit_down", uo_out, 8'h4F);

    // limit = 0 in wrap mode: count stuck at 0 both directions.
    uio_in = 8'h00;
    ui_in  = LIM;
    tick(1);
    ui_in = UP;
    tick(1);
    check("lim0_up_first", uo_out, 8'h00);
    tick(1);
    check("lim0_up_hold", uo_out, 8'h00);
    ui_in = DOWN;
    tick(1);
    check("lim0_down_hold", uo_out, 8'h00);

    ui_in = IDLE;
    check_uio("end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
